packet_transmitter: RTL and testbench

Builds Ethernet/IPv4/UDP frames around a stream of 32-bit payload words and pushes them into the MAC write FIFO interface (32-bit words, sof/eof flags, src_rdy/dst_rdy). Each frame carries a 16-bit per-frame sequence counter in the first payload halfword, then PAYLOAD_WORDS data words. The word layout is exactly the one our packet receiver parses, so a transmitter-to-receiver loopback is lossless. Sits between the sample/CPU data source and the MAC TX path.

---
 rtl/eth_pkt_pkg.sv | 37 +++
 rtl/ipv4_hdr_checksum.sv | 49 ++++
 rtl/packet_transmitter.sv | 190 +++++++++++++++++++
 tb/tb_packet_transmitter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkt_pkg.sv
// Shared Ethernet/IPv4/UDP framing constants and the transmitter state type.
// Used by packet_transmitter and its checksum sub-module. The packet receiver
// parses the same word layout.
package eth_pkt_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

    localparam int unsigned IP_HDR_BYTES  = 20;
    localparam int unsigned UDP_HDR_BYTES = 8;
    localparam int unsigned HDR_WORDS     = 11;
    localparam int unsigned SEQ_BYTES     = 2;

    // Bit positions inside the 4-bit MAC FIFO flag field
    localparam int unsigned SOF = 0;
    localparam int unsigned EOF = 1;

    typedef enum logic [1:0] {
        IDLE,
        CSUM,
        HDR,
        PAYLOAD
    } tx_state_e;

    // IP total length: IP header + UDP header + sequence halfword + payload
    function automatic logic [15:0] ip_total_len(input int unsigned payload_words);
        return 16'(IP_HDR_BYTES + UDP_HDR_BYTES + SEQ_BYTES + 4 * payload_words);
    endfunction

    // UDP length: UDP header + sequence halfword + payload
    function automatic logic [15:0] udp_total_len(input int unsigned payload_words);
        return 16'(UDP_HDR_BYTES + SEQ_BYTES + 4 * payload_words);
    endfunction

endpackage

// File: rtl/ipv4_hdr_checksum.sv
// Ones-complement checksum of ten 16-bit words (an IPv4 header with its
// checksum field zeroed). Free-running two-stage pipeline: the result for a
// given i_words appears on o_csum two clocks after i_words is presented.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high
//   i_words  ten 16-bit header words, [0] first
//   o_csum   folded, inverted 16-bit checksum
module ipv4_hdr_checksum (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0][15:0] i_words,
    output logic [15:0]      o_csum
);

    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;
    logic [19:0] r_sum;
    logic [15:0] r_csum;

    // Ten 16-bit words cannot exceed 20 bits, so no carry is lost here
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 10; i++) begin
            w_sum = w_sum + 20'(i_words[i]);
        end
    end

    // Two folds: the second absorbs the at-most-one carry of the first
    always_comb begin
        w_fold1 = {1'b0, r_sum[15:0]} + 17'(r_sum[19:16]);
        w_fold2 = w_fold1[15:0] + 16'(w_fold1[16]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum  <= '0;
            r_csum <= '0;
        end else begin
            r_sum  <= w_sum;
            r_csum <= ~w_fold2;
        end
    end

    assign o_csum = r_csum;

endmodule

// File: rtl/packet_transmitter.sv
// Wraps a stream of 32-bit payload words in Ethernet/IPv4/UDP framing and
// pushes the frame into the MAC write FIFO. The first payload halfword is a
// per-frame sequence counter.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   wr_data_o/wr_flags_o        frame word and {2'b00, eof, sof} to the MAC
//   wr_src_rdy_o/wr_dst_rdy_i   handshake; a word moves when both are high
//   din/din_valid/din_ready     payload source; consumed only during PAYLOAD
//   my_mac/my_ip/dst_mac/dst_ip/src_port/dst_port
//                               addressing, latched at frame start
//   frame_sent                  one-cycle pulse after the eof word transfers
//   seq_count                   sequence number for the next frame
module packet_transmitter
    import eth_pkt_pkg::*;
#(
    parameter int unsigned PAYLOAD_WORDS = 64,
    parameter logic [7:0]  IP_TTL        = 8'h40
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_flags_o,
    output logic        wr_src_rdy_o,
    input  logic        wr_dst_rdy_i,
    input  logic [31:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [47:0] my_mac,
    input  logic [31:0] my_ip,
    input  logic [47:0] dst_mac,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    output logic        frame_sent,
    output logic [15:0] seq_count
);

    localparam logic [15:0] IP_LEN  = ip_total_len(PAYLOAD_WORDS);
    localparam logic [15:0] UDP_LEN = udp_total_len(PAYLOAD_WORDS);

    tx_state_e   r_state;
    logic        r_csum_cyc;
    logic [3:0]  r_idx;
    logic [15:0] r_cnt;
    logic [31:0] r_data;
    logic [3:0]  r_flags;
    logic        r_src_rdy;
    logic        r_frame_sent;
    logic [15:0] r_seq;

    // Shadow copies so a frame is built from one consistent address set
    logic [47:0] r_my_mac;
    logic [31:0] r_my_ip;
    logic [47:0] r_dst_mac;
    logic [31:0] r_dst_ip;
    logic [15:0] r_src_port;
    logic [15:0] r_dst_port;

    logic [9:0][15:0] w_csum_words;
    logic [15:0]      w_hdr_csum;
    logic [3:0]       w_sel_idx;
    logic [31:0]      w_hdr_word;
    logic             w_hdr_xfer;
    logic             w_pay_xfer;
    logic             w_in_payload;
    logic [3:0]       w_pay_flags;

    // Checksum field itself (word 5) is zero while summing
    assign w_csum_words = {r_dst_ip[15:0], r_dst_ip[31:16], r_my_ip[15:0], r_my_ip[31:16],
                           16'h0000, {IP_TTL, IP_PROTO_UDP}, IP_FLAGS_DF, 16'h0000,
                           IP_LEN, {IPV4_VER_IHL, 8'h00}};

    ipv4_hdr_checksum u_csum (
        .clk     (clk),
        .reset   (reset),
        .i_words (w_csum_words),
        .o_csum  (w_hdr_csum)
    );

    // Word to load next: word 0 when leaving CSUM, else the one after r_idx.
    // The checksum is stable long before word 6 is selected.
    always_comb begin
        w_sel_idx  = (r_state == HDR) ? (r_idx + 4'd1) : 4'd0;
        w_hdr_word = '0;
        case (w_sel_idx)
            4'd0:    w_hdr_word = r_dst_mac[47:16];
            4'd1:    w_hdr_word = {r_dst_mac[15:0], r_my_mac[47:32]};
            4'd2:    w_hdr_word = r_my_mac[31:0];
            4'd3:    w_hdr_word = {ETHERTYPE_IPV4, IPV4_VER_IHL, 8'h00};
            4'd4:    w_hdr_word = {IP_LEN, 16'h0000};
            4'd5:    w_hdr_word = {IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP};
            4'd6:    w_hdr_word = {w_hdr_csum, r_my_ip[31:16]};
            4'd7:    w_hdr_word = {r_my_ip[15:0], r_dst_ip[31:16]};
            4'd8:    w_hdr_word = {r_dst_ip[15:0], r_src_port};
            4'd9:    w_hdr_word = {r_dst_port, UDP_LEN};
            4'd10:   w_hdr_word = {16'h0000, r_seq};
            default: w_hdr_word = '0;
        endcase
    end

    assign w_in_payload = (r_state == PAYLOAD);
    assign w_hdr_xfer   = (r_state == HDR) && r_src_rdy && wr_dst_rdy_i;
    assign w_pay_xfer   = w_in_payload && din_valid && wr_dst_rdy_i;

    always_comb begin
        w_pay_flags      = '0;
        w_pay_flags[EOF] = (r_cnt == 16'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_csum_cyc   <= 1'b0;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_data       <= '0;
            r_flags      <= '0;
            r_src_rdy    <= 1'b0;
            r_frame_sent <= 1'b0;
            r_seq        <= '0;
            r_my_mac     <= '0;
            r_my_ip      <= '0;
            r_dst_mac    <= '0;
            r_dst_ip     <= '0;
            r_src_port   <= '0;
            r_dst_port   <= '0;
        end else begin
            r_frame_sent <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (din_valid) begin
                        r_my_mac   <= my_mac;
                        r_my_ip    <= my_ip;
                        r_dst_mac  <= dst_mac;
                        r_dst_ip   <= dst_ip;
                        r_src_port <= src_port;
                        r_dst_port <= dst_port;
                        r_csum_cyc <= 1'b0;
                        r_state    <= CSUM;
                    end
                end
                CSUM: begin
                    r_csum_cyc <= 1'b1;
                    if (r_csum_cyc) begin
                        r_idx        <= '0;
                        r_data       <= w_hdr_word;
                        r_flags      <= '0;
                        r_flags[SOF] <= 1'b1;
                        r_src_rdy    <= 1'b1;
                        r_state      <= HDR;
                    end
                end
                HDR: begin
                    if (w_hdr_xfer) begin
                        r_flags <= '0;
                        if (r_idx == 4'(HDR_WORDS - 1)) begin
                            r_cnt     <= 16'(PAYLOAD_WORDS);
                            r_src_rdy <= 1'b0;
                            r_data    <= '0;
                            r_state   <= PAYLOAD;
                        end else begin
                            r_idx  <= r_idx + 4'd1;
                            r_data <= w_hdr_word;
                        end
                    end
                end
                PAYLOAD: begin
                    if (w_pay_xfer) begin
                        r_cnt <= r_cnt - 16'd1;
                        if (r_cnt == 16'd1) begin
                            r_frame_sent <= 1'b1;
                            r_seq        <= r_seq + 16'd1;
                            r_state      <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Payload is a combinational pass-through; header words come from r_data
    assign wr_data_o    = w_in_payload ? din : r_data;
    assign wr_flags_o   = w_in_payload ? w_pay_flags : r_flags;
    assign wr_src_rdy_o = w_in_payload ? din_valid : r_src_rdy;
    assign din_ready    = w_in_payload & wr_dst_rdy_i;
    assign frame_sent   = r_frame_sent;
    assign seq_count    = r_seq;

endmodule

// File: tb/tb_packet_transmitter.sv
// Self-checking bench for packet_transmitter with PAYLOAD_WORDS=4. Expected
// frames come from a byte-level model of the Ethernet/IPv4/UDP frame that is
// packed big-endian into 32-bit words.
module tb_packet_transmitter;

    localparam int PW = 4;
    localparam int NW = 11 + PW;

    logic        clk;
    logic        reset;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_flags_o;
    logic        wr_src_rdy_o;
    logic        wr_dst_rdy_i;
    logic [31:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [47:0] cfg_my_mac;
    logic [31:0] cfg_my_ip;
    logic [47:0] cfg_dst_mac;
    logic [31:0] cfg_dst_ip;
    logic [15:0] cfg_sport;
    logic [15:0] cfg_dport;
    logic        frame_sent;
    logic [15:0] seq_count;

    packet_transmitter #(
        .PAYLOAD_WORDS (PW),
        .IP_TTL        (8'h40)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_data_o    (wr_data_o),
        .wr_flags_o   (wr_flags_o),
        .wr_src_rdy_o (wr_src_rdy_o),
        .wr_dst_rdy_i (wr_dst_rdy_i),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .my_mac       (cfg_my_mac),
        .my_ip        (cfg_my_ip),
        .dst_mac      (cfg_dst_mac),
        .dst_ip       (cfg_dst_ip),
        .src_port     (cfg_sport),
        .dst_port     (cfg_dport),
        .frame_sent   (frame_sent),
        .seq_count    (seq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_pass;

    logic [31:0] pay [PW];
    logic [31:0] exp_w [NW];
    logic [3:0]  exp_f [NW];
    logic [15:0] m_seq;
    logic [7:0]  mb [$];

    logic [31:0] got_d [64];
    logic [3:0]  got_f [64];
    int          n_got;
    int          fs_cnt;
    int          gap_hi;
    int          gap_seen;
    int          stall_chg;
    int          hdr_din_rd;
    bit          timed_out;

    function automatic void put(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mb.push_back(v[8*i +: 8]);
    endfunction

    // Frame as a byte stream: Ethernet, IPv4, UDP, sequence, payload
    function automatic void build_expected();
        int unsigned s;
        logic [15:0] cs;
        mb = {};
        put(cfg_dst_mac, 6);
        put(cfg_my_mac, 6);
        put(48'h0800, 2);
        put(48'h45, 1);
        put(48'h00, 1);
        put(48'(20 + 8 + 2 + 4 * PW), 2);
        put(48'h0000, 2);
        put(48'h4000, 2);
        put(48'h40, 1);
        put(48'h11, 1);
        put(48'h0000, 2);
        put(48'(cfg_my_ip), 4);
        put(48'(cfg_dst_ip), 4);
        s = 0;
        for (int i = 14; i < 34; i += 2) s = s + 32'({mb[i], mb[i+1]});
        while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
        cs = ~s[15:0];
        mb[24] = cs[15:8];
        mb[25] = cs[7:0];
        put(48'(cfg_sport), 2);
        put(48'(cfg_dport), 2);
        put(48'(8 + 2 + 4 * PW), 2);
        put(48'h0000, 2);
        put(48'(m_seq), 2);
        for (int i = 0; i < PW; i++) put(48'(pay[i]), 4);
        for (int w = 0; w < NW; w++) begin
            exp_w[w] = {mb[4*w], mb[4*w+1], mb[4*w+2], mb[4*w+3]};
            exp_f[w] = (w == 0) ? 4'b0001 : (w == NW - 1) ? 4'b0010 : 4'b0000;
        end
    endfunction

    function automatic void randomize_cfg();
        cfg_my_mac  = 48'({$urandom(), $urandom()});
        cfg_dst_mac = 48'({$urandom(), $urandom()});
        cfg_my_ip   = $urandom();
        cfg_dst_ip  = $urandom();
        cfg_sport   = 16'($urandom());
        cfg_dport   = 16'($urandom());
        for (int i = 0; i < PW; i++) pay[i] = $urandom();
    endfunction

    // Drives one frame and records every transfer; no checking here.
    task automatic send_frame(input bit rand_rdy, input int gap_after, input int gap_len);
        int  k;
        int  gap_left;
        int  post;
        bit  done;
        bit  in_gap;
        bit  prev_stall;
        logic [31:0] prev_d;
        n_got = 0; fs_cnt = 0; gap_hi = 0; gap_seen = 0; stall_chg = 0; hdr_din_rd = 0;
        k = 0; gap_left = gap_len; post = 0; done = 0; prev_stall = 0; prev_d = '0;
        for (int cyc = 0; cyc < 500 && post < 3; cyc++) begin
            @(negedge clk);
            wr_dst_rdy_i = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_gap = (k == gap_after) && (gap_left > 0);
            din_valid = !done && !in_gap;
            din = (k < PW) ? pay[k] : 32'hDEAD_BEEF;
            #1;
            if (in_gap) begin
                gap_seen++;
                gap_left--;
                if (wr_src_rdy_o) gap_hi++;
            end
            if (prev_stall && wr_data_o !== prev_d) stall_chg++;
            if (frame_sent) fs_cnt++;
            if (din_ready && n_got < 11) hdr_din_rd++;
            if (wr_src_rdy_o && wr_dst_rdy_i) begin
                if (n_got < 64) begin
                    got_d[n_got] = wr_data_o;
                    got_f[n_got] = wr_flags_o;
                end
                n_got++;
                if (wr_flags_o[1]) done = 1;
            end
            if (din_valid && din_ready) k++;
            prev_stall = wr_src_rdy_o && !wr_dst_rdy_i;
            prev_d = wr_data_o;
            if (done) post++;
        end
        timed_out = !done;
        din_valid = 1'b0;
        wr_dst_rdy_i = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        din_valid = 1'b0;
        wr_dst_rdy_i = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (wr_src_rdy_o !== 1'b0) $display("FAIL reset_src_rdy got=%0h exp=0", wr_src_rdy_o);
        else n_pass++;
        n_checks++;
        if (wr_flags_o !== 4'h0) $display("FAIL reset_flags got=%0h exp=0", wr_flags_o);
        else n_pass++;
        n_checks++;
        if (wr_data_o !== 32'h0) $display("FAIL reset_data got=%h exp=0", wr_data_o);
        else n_pass++;
        n_checks++;
        if (din_ready !== 1'b0) $display("FAIL reset_din_ready got=%0h exp=0", din_ready);
        else n_pass++;
        n_checks++;
        if (frame_sent !== 1'b0) $display("FAIL reset_frame_sent got=%0h exp=0", frame_sent);
        else n_pass++;
        n_checks++;
        if (seq_count !== 16'h0) $display("FAIL reset_seq got=%h exp=0", seq_count);
        else n_pass++;
        m_seq = 16'h0;
    endtask

    task automatic test_basic();
        randomize_cfg();
        cfg_my_ip  = 32'hC0A8_010A;
        cfg_dst_ip = 32'hC0A8_0101;
        build_expected();
        send_frame(1'b0, -1, 0);
        n_checks++;
        if (timed_out || n_got !== NW) $display("FAIL basic_len got=%0d exp=%0d", n_got, NW);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            n_checks++;
            if (got_d[i] !== exp_w[i] || got_f[i] !== exp_f[i])
                $display("FAIL basic_word%0d got=%h/%h exp=%h/%h", i, got_d[i], got_f[i],
                         exp_w[i], exp_f[i]);
            else n_pass++;
        end
        n_checks++;
        if (got_d[4] !== 32'h002E_0000) $display("FAIL basic_iplen got=%h exp=002e0000", got_d[4]);
        else n_pass++;
        n_checks++;
        if (got_d[6] !== 32'hB763_C0A8) $display("FAIL basic_csum got=%h exp=b763c0a8", got_d[6]);
        else n_pass++;
        n_checks++;
        if (got_d[9] !== {cfg_dport, 16'h001A})
            $display("FAIL basic_udplen got=%h exp=%h", got_d[9], {cfg_dport, 16'h001A});
        else n_pass++;
        n_checks++;
        if (got_d[10] !== 32'h0) $display("FAIL basic_seq_word got=%h exp=0", got_d[10]);
        else n_pass++;
        n_checks++;
        if (fs_cnt !== 1) $display("FAIL basic_frame_sent got=%0d exp=1", fs_cnt);
        else n_pass++;
        n_checks++;
        if (hdr_din_rd !== 0) $display("FAIL basic_hdr_din_ready got=%0d exp=0", hdr_din_rd);
        else n_pass++;
        m_seq = m_seq + 16'd1;
        n_checks++;
        if (seq_count !== m_seq) $display("FAIL basic_seq_inc got=%h exp=%h", seq_count, m_seq);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        for (int f = 0; f < 2; f++) begin
            randomize_cfg();
            build_expected();
            send_frame(1'b1, -1, 0);
            n_checks++;
            if (timed_out || n_got !== NW) $display("FAIL bp_len got=%0d exp=%0d", n_got, NW);
            else n_pass++;
            for (int i = 0; i < NW; i++) begin
                n_checks++;
                if (got_d[i] !== exp_w[i] || got_f[i] !== exp_f[i])
                    $display("FAIL bp_word%0d got=%h/%h exp=%h/%h", i, got_d[i], got_f[i],
                             exp_w[i], exp_f[i]);
                else n_pass++;
            end
            n_checks++;
            if (stall_chg !== 0) $display("FAIL bp_hold_stable got=%0d exp=0", stall_chg);
            else n_pass++;
            n_checks++;
            if (fs_cnt !== 1) $display("FAIL bp_frame_sent got=%0d exp=1", fs_cnt);
            else n_pass++;
            m_seq = m_seq + 16'd1;
        end
    endtask

    task automatic test_underrun();
        randomize_cfg();
        build_expected();
        send_frame(1'b0, 2, 5);
        n_checks++;
        if (gap_seen !== 5 || gap_hi !== 0)
            $display("FAIL underrun_gap got=%0d/%0d exp=5/0", gap_seen, gap_hi);
        else n_pass++;
        n_checks++;
        if (timed_out || n_got !== NW) $display("FAIL underrun_len got=%0d exp=%0d", n_got, NW);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            n_checks++;
            if (got_d[i] !== exp_w[i] || got_f[i] !== exp_f[i])
                $display("FAIL underrun_word%0d got=%h/%h exp=%h/%h", i, got_d[i], got_f[i],
                         exp_w[i], exp_f[i]);
            else n_pass++;
        end
        m_seq = m_seq + 16'd1;
    endtask

    task automatic test_seq_wrap();
        @(negedge clk);
        force dut.r_seq = 16'hFFFF;
        @(negedge clk);
        release dut.r_seq;
        m_seq = 16'hFFFF;
        n_checks++;
        if (seq_count !== 16'hFFFF) $display("FAIL wrap_preload got=%h exp=ffff", seq_count);
        else n_pass++;
        for (int f = 0; f < 2; f++) begin
            randomize_cfg();
            build_expected();
            send_frame(1'b0, -1, 0);
            n_checks++;
            if (timed_out || got_d[10] !== exp_w[10])
                $display("FAIL wrap_word10_f%0d got=%h exp=%h", f, got_d[10], exp_w[10]);
            else n_pass++;
            m_seq = m_seq + 16'd1;
            n_checks++;
            if (seq_count !== m_seq) $display("FAIL wrap_seq_f%0d got=%h exp=%h", f, seq_count, m_seq);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int  xfers;
        bit  hit;
        randomize_cfg();
        build_expected();
        xfers = 0;
        hit = 0;
        for (int cyc = 0; cyc < 100 && !hit; cyc++) begin
            @(negedge clk);
            din_valid = 1'b1;
            wr_dst_rdy_i = 1'b1;
            din = pay[0];
            #1;
            if (xfers == 5 && wr_src_rdy_o) hit = 1;
            else if (wr_src_rdy_o && wr_dst_rdy_i) xfers++;
        end
        n_checks++;
        if (!hit || wr_data_o !== exp_w[5])
            $display("FAIL midreset_word5 got=%h exp=%h", wr_data_o, exp_w[5]);
        else n_pass++;
        reset = 1'b1;
        din_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (wr_src_rdy_o !== 1'b0 || seq_count !== 16'h0)
            $display("FAIL midreset_state got=%0h/%h exp=0/0000", wr_src_rdy_o, seq_count);
        else n_pass++;
        m_seq = 16'h0;
        randomize_cfg();
        build_expected();
        send_frame(1'b0, -1, 0);
        n_checks++;
        if (timed_out || n_got !== NW) $display("FAIL midreset_len got=%0d exp=%0d", n_got, NW);
        else n_pass++;
        for (int i = 0; i < NW; i++) begin
            n_checks++;
            if (got_d[i] !== exp_w[i] || got_f[i] !== exp_f[i])
                $display("FAIL midreset_word%0d got=%h/%h exp=%h/%h", i, got_d[i], got_f[i],
                         exp_w[i], exp_f[i]);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        din = '0;
        din_valid = 1'b0;
        wr_dst_rdy_i = 1'b1;
        m_seq = '0;
        randomize_cfg();
        test_reset();
        test_basic();
        test_back_pressure();
        test_underrun();
        test_seq_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
